// File: rtl/qpsk_mod_demod_link_if.sv
// rtl/qpsk_mod_demod_link_if.sv - bit-pair, symbol and received-sample signals of the QPSK link
// master drives the bit pairs, received samples and loopback; slave is the mapper/demapper.
interface qpsk_mod_demod_link_if #(
   parameter int WIDTH = 16
);
   logic             mod_valid_in;
   logic             in_odd;
   logic             in_even;
   logic [WIDTH-1:0] out_re;
   logic [WIDTH-1:0] out_im;
   logic             mod_valid_out;
   logic             demod_valid_in;
   logic [WIDTH-1:0] in_re;
   logic [WIDTH-1:0] in_im;
   logic             loopback;
   logic             out_odd;
   logic             out_even;
   logic             demod_valid_out;

   modport master (
      output mod_valid_in, in_odd, in_even,
      output demod_valid_in, in_re, in_im, loopback,
      input  out_re, out_im, mod_valid_out,
      input  out_odd, out_even, demod_valid_out
   );

   modport slave (
      input  mod_valid_in, in_odd, in_even,
      input  demod_valid_in, in_re, in_im, loopback,
      output out_re, out_im, mod_valid_out,
      output out_odd, out_even, demod_valid_out
   );
endinterface

// File: rtl/qpsk_mod_demod_link.sv
// rtl/qpsk_mod_demod_link.sv - registered QPSK mapper and hard-decision demapper with loopback
// Both paths have one register stage; loopback feeds the mapper's registers into the slicer.
module qpsk_mod_demod_link #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] POS_LEVEL = 16'h16A0,
   parameter logic [WIDTH-1:0] NEG_LEVEL = 16'h895F
) (
   input  logic                   clk,
   input  logic                   reset,
   qpsk_mod_demod_link_if.slave   link
);

   logic [WIDTH-1:0] re_q, re_d;
   logic [WIDTH-1:0] im_q, im_d;
   logic             mod_valid_q, mod_valid_d;
   logic             odd_q, odd_d;
   logic             even_q, even_d;
   logic             demod_valid_q, demod_valid_d;

   logic [WIDTH-1:0] src_re;
   logic [WIDTH-1:0] src_im;
   logic             src_valid;

   // Loopback uses the registered symbol, so a pair takes two edges to come back.
   always_comb begin
      src_re    = link.in_re;
      src_im    = link.in_im;
      src_valid = link.demod_valid_in;
      if (link.loopback) begin
         src_re    = re_q;
         src_im    = im_q;
         src_valid = mod_valid_q;
      end
   end

   always_comb begin
      re_d        = re_q;
      im_d        = im_q;
      mod_valid_d = link.mod_valid_in;
      if (link.mod_valid_in) begin
         re_d = link.in_odd  ? POS_LEVEL : NEG_LEVEL;
         im_d = link.in_even ? POS_LEVEL : NEG_LEVEL;
      end
   end

   // Sign-bit slicer: zero decides 1, no magnitude qualification.
   always_comb begin
      odd_d         = odd_q;
      even_d        = even_q;
      demod_valid_d = src_valid;
      if (src_valid) begin
         odd_d  = ~src_re[WIDTH-1];
         even_d = ~src_im[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         re_q          <= '0;
         im_q          <= '0;
         mod_valid_q   <= 1'b0;
         odd_q         <= 1'b0;
         even_q        <= 1'b0;
         demod_valid_q <= 1'b0;
      end else begin
         re_q          <= re_d;
         im_q          <= im_d;
         mod_valid_q   <= mod_valid_d;
         odd_q         <= odd_d;
         even_q        <= even_d;
         demod_valid_q <= demod_valid_d;
      end
   end

   assign link.out_re          = re_q;
   assign link.out_im          = im_q;
   assign link.mod_valid_out   = mod_valid_q;
   assign link.out_odd         = odd_q;
   assign link.out_even        = even_q;
   assign link.demod_valid_out = demod_valid_q;

endmodule

// File: tb/tb_qpsk_mod_demod_link.sv
// tb/tb_qpsk_mod_demod_link.sv - table vectors, random loopback against a reference model, reset corners
module tb_qpsk_mod_demod_link;

   localparam int POS = 5792;
   localparam int NEG = -30369;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   qpsk_mod_demod_link_if #(.WIDTH(16)) link ();

   qpsk_mod_demod_link dut (
      .clk   (clk),
      .reset (reset),
      .link  (link)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mv;
      logic        odd;
      logic        even;
      logic        dv;
      logic [15:0] re;
      logic [15:0] im;
      logic [15:0] exp_re;
      logic [15:0] exp_im;
      logic        exp_mv;
      logic        exp_odd;
      logic        exp_even;
      logic        exp_dv;
   } vec_t;

   vec_t tbl [8];

   typedef struct {
      logic mv;
      logic odd;
      logic even;
   } pair_t;

   pair_t hist [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic mv, input logic odd, input logic even,
                        input logic dv, input logic [15:0] re, input logic [15:0] im,
                        input logic lb);
      link.mod_valid_in   = mv;
      link.in_odd         = odd;
      link.in_even        = even;
      link.demod_valid_in = dv;
      link.in_re          = re;
      link.in_im          = im;
      link.loopback       = lb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] all_out();
      return {link.out_re, link.out_im, link.mod_valid_out,
              link.out_odd, link.out_even, link.demod_valid_out};
   endfunction

   function automatic int level(input logic b);
      return b ? POS : NEG;
   endfunction

   initial begin
      int   m_re;
      int   m_im;
      logic h_odd;
      logic h_even;
      int   e_odd;
      int   e_even;
      int   e_dv;
      pair_t p;
      pair_t prev;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h16A0, 16'h895F, 16'h895F, 16'h895F, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h8000, 16'h895F, 16'h16A0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h7FFF, 16'hFFFF, 16'h16A0, 16'h895F, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h8000, 16'h7FFF, 16'h16A0, 16'h16A0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h7000, 16'h8000, 16'h16A0, 16'h16A0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h9999, 16'h16A0, 16'h16A0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h16A0, 16'h16A0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'hFFFE, 16'h895F, 16'h895F, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset held with inputs toggling
      drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1000, 16'h2000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("reset_hold_%0d", i), all_out(), 64'h0);
         drive(i[0], ~i[0], i[0], 1'b1, 16'h7FFF, 16'h0001, i[1]);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      #2 reset = 1'b1;
      #1 chk("reset_release_between_edges", all_out(), 64'h0);
      tick();
      chk("first_edge_no_valid", all_out(), 64'h0);

      // Mapper sweep, slicer vectors and valid gaps
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].mv, tbl[i].odd, tbl[i].even, tbl[i].dv, tbl[i].re, tbl[i].im, 1'b0);
         tick();
         chk($sformatf("vec%0d_symbol", i),
             {31'b0, link.out_re, link.out_im, link.mod_valid_out},
             {31'b0, tbl[i].exp_re, tbl[i].exp_im, tbl[i].exp_mv});
         chk($sformatf("vec%0d_bits", i),
             {61'b0, link.out_odd, link.out_even, link.demod_valid_out},
             {61'b0, tbl[i].exp_odd, tbl[i].exp_even, tbl[i].exp_dv});
      end

      // Flush into loopback; the last table symbol (00) is decoded during the flush.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
      repeat (3) tick();
      m_re   = NEG;
      m_im   = NEG;
      h_odd  = 1'b0;
      h_even = 1'b0;
      hist.push_back('{1'b0, 1'b0, 1'b0});

      for (int n = 0; n < 104; n++) begin
         if (n < 4) begin
            p = '{1'b1, n[1], n[0]};
         end else begin
            p.mv   = ($urandom_range(0, 3) != 0);
            p.odd  = 1'($urandom_range(0, 1));
            p.even = 1'($urandom_range(0, 1));
         end
         drive(p.mv, p.odd, p.even, 1'($urandom_range(0, 1)),
               16'($urandom), 16'($urandom), 1'b1);
         hist.push_back(p);
         tick();
         if (p.mv) begin
            m_re = level(p.odd);
            m_im = level(p.even);
         end
         prev = hist[hist.size() - 2];
         if (prev.mv) begin
            h_odd  = prev.odd;
            h_even = prev.even;
         end
         e_dv   = prev.mv ? 1 : 0;
         e_odd  = h_odd  ? 1 : 0;
         e_even = h_even ? 1 : 0;
         chk($sformatf("lb%0d_symbol", n),
             {int'($signed(link.out_re)), int'($signed(link.out_im))},
             {m_re, m_im});
         chk($sformatf("lb%0d_bits", n),
             {link.mod_valid_out, link.out_odd, link.out_even, link.demod_valid_out},
             {p.mv, e_odd[0], e_even[0], e_dv[0]});
      end

      // Reset pulled mid-cycle during loopback traffic
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
      tick();
      tick();
      #2 reset = 1'b0;
      #1 chk("midstream_reset_immediate", all_out(), 64'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1);
      tick();
      chk("midstream_reset_held", all_out(), 64'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      #2 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_reset_quiet_%0d", i), all_out(), 64'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
